// File: rtl/sb_pkg.sv
// Shared types and sizing for the store buffer: entry record and pointer/count widths.
// The entry field widths are the data_memory address and data widths.
package sb_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup: finds the youngest occupied entry whose address
// equals the load address and returns its data.
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  sb_entry_t                    i_entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     i_head,
    input  logic [$clog2(DEPTH+1)-1:0]   i_count,
    input  logic [SB_ADDR_W-1:0]         i_ld_addr,
    output logic                         o_hit,
    output logic [SB_DATA_W-1:0]         o_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] w_idx;

    // Walk entries oldest to youngest by age (idx - head); the last match wins,
    // which keeps priority correct across the pointer wrap.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int age = 0; age < DEPTH; age++) begin
            w_idx = i_head + PW'(age);
            if ((CW'(age) < i_count) && (i_entries[w_idx].addr == i_ld_addr)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO of pending stores between MEM and data_memory: loads own the memory port,
// buffered stores drain one per idle cycle, and loads see the youngest buffered store.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         st_valid,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W-1:0]            st_data,
    output logic                         st_ready,
    input  logic                         ld_valid,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic [DATA_W-1:0]            ld_data,
    output logic                         ld_hit,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [DATA_W-1:0]            mem_write_data,
    input  logic [DATA_W-1:0]            mem_read_data,
    output logic                         sb_empty,
    output logic [$clog2(DEPTH+1)-1:0]   sb_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    sb_entry_t       r_entries [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_ld_miss;
    logic            w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign st_ready  = !w_full;
    assign sb_empty  = w_empty;
    assign sb_count  = r_count;
    assign w_push    = st_valid && !w_full;
    assign ld_hit    = ld_valid && w_fwd_hit;
    assign w_ld_miss = ld_valid && !w_fwd_hit;
    assign w_pop     = mem_write;

    sb_fwd_match #(
        .DEPTH     (DEPTH)
    ) u_fwd_match (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_ld_addr (ld_addr),
        .o_hit     (w_fwd_hit),
        .o_data    (w_fwd_data)
    );

    always_comb begin
        ld_data = '0;
        if (ld_hit) begin
            ld_data = w_fwd_data;
        end else if (ld_valid) begin
            ld_data = mem_read_data;
        end
    end

    // A missing load owns the single port; otherwise the oldest store drains.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (w_ld_miss) begin
            mem_read    = 1'b1;
            mem_address = ld_addr;
        end else if (!w_empty) begin
            mem_write      = 1'b1;
            mem_address    = r_entries[r_head].addr;
            mem_write_data = r_entries[r_head].data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry contents need no reset; occupancy is carried entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_tail] <= '{addr: st_addr, data: st_data};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a FIFO scoreboard predicts every cycle's outputs and drains,
// load-lookup tables check forwarding, and short sequences cover full, wrap and reset.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          st_valid = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic          st_ready;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data;
    logic          ld_hit;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic          sb_empty;
    logic [2:0]    sb_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } storeRec_t;

    typedef struct {
        logic          ldValid;
        logic [AW-1:0] ldAddr;
        logic          expHit;
        logic [DW-1:0] expData;
        logic          expRead;
    } loadVec_t;

    storeRec_t     expQ [$];
    loadVec_t      vecs [$];
    logic [DW-1:0] tbMem  [16];
    logic [DW-1:0] refMem [16];

    logic          mHit;
    logic [DW-1:0] mData;
    logic          mRead;
    logic          mWrite;
    logic          mAccept;
    logic [DW-1:0] mLdData;

    store_buffer #(
        .DEPTH          (DEPTH),
        .ADDR_W         (AW),
        .DATA_W         (DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_hit         (ld_hit),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .sb_empty       (sb_empty),
        .sb_count       (sb_count)
    );

    always #20 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbMem[i]  = 32'h100 + i;
            refMem[i] = 32'h100 + i;
        end
    end

    // Behavioural data_memory: combinational read, write on posedge.
    assign mem_read_data = tbMem[mem_address[3:0]];
    always @(posedge clk) begin
        if (mem_write) begin
            tbMem[mem_address[3:0]] <= mem_write_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                                 input logic lv, input logic [AW-1:0] la);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_valid = lv;
        ld_addr  = la;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic runTable(input string name);
        foreach (vecs[i]) begin
            ld_valid = vecs[i].ldValid;
            ld_addr  = vecs[i].ldAddr;
            #2;
            checkOutput({name, " ld_hit"},   32'(ld_hit),   32'(vecs[i].expHit));
            checkOutput({name, " ld_data"},  ld_data,       vecs[i].expData);
            checkOutput({name, " mem_read"}, 32'(mem_read), 32'(vecs[i].expRead));
        end
        vecs.delete();
    endtask

    // Scoreboard: predicts mid-cycle outputs from the expected FIFO, then commits
    // what the coming posedge will do (drain oldest, accept store if not full).
    always @(negedge clk) begin
        if (rst_n) begin
            mHit  = 1'b0;
            mData = '0;
            foreach (expQ[i]) begin
                if (expQ[i].addr == ld_addr) begin
                    mHit  = 1'b1;
                    mData = expQ[i].data;
                end
            end
            mHit    = mHit && ld_valid;
            mRead   = ld_valid && !mHit;
            mWrite  = !mRead && (expQ.size() > 0);
            mLdData = mHit ? mData : (ld_valid ? tbMem[ld_addr[3:0]] : '0);
            mAccept = st_valid && (expQ.size() < DEPTH);

            checkOutput("sb st_ready",  32'(st_ready),  32'(expQ.size() < DEPTH));
            checkOutput("sb sb_count",  32'(sb_count),  32'(expQ.size()));
            checkOutput("sb sb_empty",  32'(sb_empty),  32'(expQ.size() == 0));
            checkOutput("sb ld_hit",    32'(ld_hit),    32'(mHit));
            checkOutput("sb ld_data",   ld_data,        mLdData);
            checkOutput("sb mem_read",  32'(mem_read),  32'(mRead));
            checkOutput("sb mem_write", 32'(mem_write), 32'(mWrite));
            if (mRead) begin
                checkOutput("sb rd addr", mem_address, ld_addr);
            end else if (mWrite) begin
                checkOutput("sb wr addr", mem_address,    expQ[0].addr);
                checkOutput("sb wr data", mem_write_data, expQ[0].data);
            end else begin
                checkOutput("sb idle addr", mem_address,    '0);
                checkOutput("sb idle data", mem_write_data, '0);
            end

            if (mWrite) begin
                refMem[expQ[0].addr[3:0]] = expQ[0].data;
                void'(expQ.pop_front());
            end
            if (mAccept) begin
                expQ.push_back('{addr: st_addr, data: st_data});
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #5;
        $display("[TB] reset state");
        checkOutput("rst sb_empty",  32'(sb_empty),  32'd1);
        checkOutput("rst sb_count",  32'(sb_count),  32'd0);
        checkOutput("rst st_ready",  32'(st_ready),  32'd1);
        checkOutput("rst mem_write", 32'(mem_write), 32'd0);
        checkOutput("rst mem_read",  32'(mem_read),  32'd0);
        checkOutput("rst ld_data",   ld_data,        32'd0);
        #25 rst_n = 1'b1;

        $display("[TB] single store while idle");
        waitCycle();
        applyStimulus(1'b1, 32'd5, 32'h11, 1'b0, 32'd0);
        checkOutput("t1 st_ready", 32'(st_ready), 32'd1);
        waitCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        checkOutput("t1 mem_write", 32'(mem_write), 32'd1);
        checkOutput("t1 mem_addr",  mem_address,    32'd5);
        checkOutput("t1 mem_wdata", mem_write_data, 32'h11);
        waitCycle();
        checkOutput("t1 sb_empty", 32'(sb_empty), 32'd1);
        checkOutput("t1 mem[5]",   tbMem[5],      32'h11);

        $display("[TB] fill under load pressure, then drain with store held");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 32'(i), 32'h20 + 32'(i), 1'b1, 32'd9);
            waitCycle();
        end
        applyStimulus(1'b1, 32'd6, 32'h25, 1'b1, 32'd9);
        checkOutput("t2 full st_ready", 32'(st_ready), 32'd0);
        checkOutput("t2 full count",    32'(sb_count), 32'd4);
        waitCycle();
        checkOutput("t2 refused count", 32'(sb_count), 32'd4);
        waitCycle();
        ld_valid = 1'b0;
        #1;
        checkOutput("t2 pop st_ready",  32'(st_ready),  32'd0);
        checkOutput("t2 pop mem_write", 32'(mem_write), 32'd1);
        waitCycle();
        ld_valid = 1'b1;
        checkOutput("t2 freed st_ready", 32'(st_ready), 32'd1);
        checkOutput("t2 freed count",    32'(sb_count), 32'd3);
        waitCycle();
        checkOutput("t2 refill count", 32'(sb_count), 32'd4);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        repeat (6) waitCycle();

        $display("[TB] duplicate address forwarding");
        applyStimulus(1'b1, 32'd7, 32'hA, 1'b1, 32'd9);
        waitCycle();
        applyStimulus(1'b1, 32'd7, 32'hB, 1'b1, 32'd9);
        waitCycle();
        st_valid = 1'b0;
        vecs.push_back('{1'b1, 32'd7, 1'b1, 32'hB,   1'b0});
        vecs.push_back('{1'b1, 32'd9, 1'b0, 32'h109, 1'b1});
        vecs.push_back('{1'b0, 32'd7, 1'b0, 32'h0,   1'b0});
        vecs.push_back('{1'b1, 32'd5, 1'b0, 32'h11,  1'b1});
        vecs.push_back('{1'b1, 32'd8, 1'b0, 32'h108, 1'b1});
        runTable("t3");
        waitCycle();
        ld_valid = 1'b0;
        repeat (4) waitCycle();

        $display("[TB] wrap-around youngest match");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'd10 + 32'(i), 32'h31 + 32'(i), 1'b1, 32'd9);
            waitCycle();
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        repeat (4) waitCycle();
        applyStimulus(1'b1, 32'd7, 32'hC, 1'b1, 32'd9);
        waitCycle();
        applyStimulus(1'b1, 32'd7, 32'hD, 1'b1, 32'd9);
        waitCycle();
        st_valid = 1'b0;
        vecs.push_back('{1'b1, 32'd7,  1'b1, 32'hD,  1'b0});
        vecs.push_back('{1'b1, 32'd10, 1'b0, 32'h31, 1'b1});
        vecs.push_back('{1'b1, 32'd12, 1'b0, 32'h33, 1'b1});
        vecs.push_back('{1'b0, 32'd10, 1'b0, 32'h0,  1'b0});
        vecs.push_back('{1'b1, 32'd7,  1'b1, 32'hD,  1'b0});
        runTable("t4");
        waitCycle();
        applyStimulus(1'b1, 32'd7, 32'hE, 1'b1, 32'd7);
        #1;
        checkOutput("t4 same-cycle ld_hit",  32'(ld_hit), 32'd1);
        checkOutput("t4 same-cycle ld_data", ld_data,     32'hD);
        waitCycle();
        st_valid = 1'b0;
        #1;
        checkOutput("t4 after push ld_data", ld_data, 32'hE);
        waitCycle();
        ld_valid = 1'b0;
        repeat (5) waitCycle();
        checkOutput("t4 mem[7] last store", tbMem[7], 32'hE);

        $display("[TB] reset with pending stores");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'd13 + 32'(i), 32'h41 + 32'(i), 1'b1, 32'd9);
            waitCycle();
        end
        checkOutput("t6 pending count", 32'(sb_count), 32'd3);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        #1 rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("t6 rst sb_count",  32'(sb_count),  32'd0);
        checkOutput("t6 rst sb_empty",  32'(sb_empty),  32'd1);
        checkOutput("t6 rst mem_write", 32'(mem_write), 32'd0);
        checkOutput("t6 rst st_ready",  32'(st_ready),  32'd1);
        checkOutput("t6 rst mem_read",  32'(mem_read),  32'd0);
        @(posedge clk);
        #5 rst_n = 1'b1;
        repeat (5) waitCycle();
        for (int i = 13; i <= 15; i++) begin
            checkOutput("t6 no stale write", tbMem[i], 32'h100 + 32'(i));
        end

        for (int i = 0; i < 16; i++) begin
            checkOutput("final memory", tbMem[i], refMem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO of pending stores between the pipeline MEM stage and data_memory.
- Decouples store issue from memory-port availability, so that loads get priority on the single data_memory port.
- Forwards the youngest matching buffered store to a load (store-to-load bypass), so loads always see program-order data.
- Drains one store per cycle into data_memory whenever the port is not taken by a load.

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of 2 and ≥2.
- ADDR_W, 32, word-address width; matches data_memory address.
- DATA_W, 32, data width; matches data_memory write_data/read_data.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request from MEM stage.
- st_addr  in  ADDR_W  store word address.
- st_data  in  DATA_W  store data.
- st_ready  out  1  buffer can accept a store this cycle; equals !full.
- ld_valid  in  1  load request from MEM stage.
- ld_addr  in  ADDR_W  load word address.
- ld_data  out  DATA_W  load result, combinational, same cycle.
- ld_hit  out  1  load was served from the buffer.
- mem_read  out  1  to data_memory mem_read.
- mem_write  out  1  to data_memory mem_write.
- mem_address  out  ADDR_W  to data_memory address.
- mem_write_data  out  DATA_W  to data_memory write_data.
- mem_read_data  in  DATA_W  from data_memory read_data (combinational).
- sb_empty  out  1  no pending stores; used for fences and halt.
- sb_count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage is a circular buffer: DEPTH entries of {addr, data}, head pointer (oldest), tail pointer (next free), and count.
- Reset is asynchronous on rst_n low:
  - head = tail = count = 0.
  - Entry contents don't-care; valid state is derived from count.
  - Pending stores are discarded, including on reset mid-drain.
  - Outputs while in reset: sb_empty=1, sb_count=0, st_ready=1, mem_write=0, mem_read=0 (when ld_valid=0).
- Push: on posedge, if st_valid && st_ready, write {st_addr, st_data} at tail, then tail = tail+1 (mod DEPTH).
  - If st_valid && !st_ready, the store is not taken; the MEM stage must stall and hold its request.
- Load lookup (combinational):
  - Compare ld_addr against every occupied entry, full-width equality.
  - ld_hit = ld_valid && any match.
  - ld_data = data of the youngest matching entry (closest to tail) when ld_hit; else mem_read_data when ld_valid; else 0.
- Memory port arbitration (combinational, one access per cycle):
  - ld_valid && !ld_hit: mem_read=1, mem_address=ld_addr, mem_write=0. Drain is blocked this cycle.
  - else if !sb_empty: mem_write=1, mem_address=head addr, mem_write_data=head data, mem_read=0. Pop occurs at posedge.
  - else: mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
- Pop: on posedge when mem_write=1, head = head+1 (mod DEPTH).
- Latency:
  - A store becomes visible in memory no earlier than the cycle after it is pushed.
  - A load completes in 0 cycles (same cycle).
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - st_valid and ld_valid in the same cycle: the store is pushed, and the load sees buffer contents before that push (no forwarding from the incoming store).
- Full: st_ready=0 even if a pop happens in the same cycle. There is no same-cycle bypass of full.
- Wrap-around: pointers wrap modulo DEPTH. Youngest-match priority must be correct across the wrap boundary; compute age as (idx - head) mod DEPTH.
- Duplicate addresses: no coalescing. Each store drains in order, so the final memory value is the last store.
- Loads never modify buffer state.

Decomposition:
- Shared package sb_pkg:
  - Entry struct/typedef {addr, data}.
  - Pointer width constant PTR_W = $clog2(DEPTH).
- One sub-module, sb_fwd_match:
  - Inputs: entry array, head, count, ld_addr.
  - Outputs: hit and forwarded data, using youngest-first priority.
- Top level holds pointers, count, storage, and arbitration.

Test Plan:
- Reset, then store A=5/D=0x11 while idle: st_ready=1; next cycle mem_write=1, addr 5, data 0x11; following cycle sb_empty=1 and data_memory[5]=0x11.
- Hold ld_valid with a miss on addr 9 for 6 cycles while pushing 4 stores (addr 1..4): after the 4th push st_ready=0 and sb_count=4; a 5th store is not accepted; mem_write=0 throughout.
- Stores to addr 7 with data 0xA then 0xB, both still buffered; load addr 7 → ld_hit=1, ld_data=0xB, mem_read=0.
- Wrap-around: push 3 stores and drain 3, then push addr 7/0xC (slot 3) and addr 7/0xD (slot 0, wrapped) → load addr 7 returns 0xD.
- Buffer full and draining, with st_valid held: push is refused while count=4; it is accepted the cycle after a pop frees an entry, with count returning to 4.
- Assert rst_n low mid-sequence with 3 entries pending: sb_count=0, sb_empty=1, mem_write=0 immediately (async); after release, no stale writes reach data_memory.
